// File: rtl/oldest_report_keeper_pkg.sv
// Shared ROB-age types and the wrap-aware older_than() compare used by the report keeper.
// Pure package: no state, no latency, no flow control.
package oldest_report_keeper_pkg;

   localparam int ROB_ENTRIES = 64;
   localparam int IDX_W       = $clog2(ROB_ENTRIES);
   localparam int DATA_W      = 4;

   typedef struct packed {
      logic             flipped;
      logic [IDX_W-1:0] idx;
   } rob_idx_t;

   typedef logic [DATA_W-1:0] data_t;

   // The flipped bit toggles on each ROB wrap, so differing flips invert the raw idx order.
   function automatic logic older_than(input rob_idx_t a, input rob_idx_t b);
      if (a.flipped == b.flipped) return (a.idx < b.idx);
      else                        return (a.idx > b.idx);
   endfunction

endpackage

// File: rtl/oldest_report_keeper_tree.sv
// report_tree_min: recursive N->1 oldest-of-valid selector; combinational, no backpressure.
// On equal age the lower-numbered port wins.
module report_tree_min
   import oldest_report_keeper_pkg::*;
#(
   parameter int N = 4
) (
   input  logic     [N-1:0] i_vld,
   input  rob_idx_t [N-1:0] i_idx,
   input  data_t    [N-1:0] i_data,
   output logic             o_any_vld,
   output rob_idx_t         o_idx,
   output data_t            o_data
);

   generate
      if (N == 1) begin : g_leaf
         assign o_any_vld = i_vld[0];
         assign o_idx     = i_idx[0];
         assign o_data    = i_data[0];
      end else begin : g_node
         localparam int LO = N / 2;
         localparam int HI = N - LO;

         logic     lo_vld, hi_vld;
         rob_idx_t lo_idx, hi_idx;
         data_t    lo_data, hi_data;
         logic     pick_hi;

         report_tree_min #(.N(LO)) u_lo (
            .i_vld     (i_vld[LO-1:0]),
            .i_idx     (i_idx[LO-1:0]),
            .i_data    (i_data[LO-1:0]),
            .o_any_vld (lo_vld),
            .o_idx     (lo_idx),
            .o_data    (lo_data)
         );

         report_tree_min #(.N(HI)) u_hi (
            .i_vld     (i_vld[N-1:LO]),
            .i_idx     (i_idx[N-1:LO]),
            .i_data    (i_data[N-1:LO]),
            .o_any_vld (hi_vld),
            .o_idx     (hi_idx),
            .o_data    (hi_data)
         );

         // Strict compare: a tie falls to the lower half.
         always_comb begin
            pick_hi = hi_vld && (!lo_vld || older_than(hi_idx, lo_idx));
         end

         assign o_any_vld = lo_vld | hi_vld;
         assign o_idx     = pick_hi ? hi_idx  : lo_idx;
         assign o_data    = pick_hi ? hi_data : lo_data;
      end
   endgenerate

endmodule

// File: rtl/oldest_report_keeper.sv
// Keeps the oldest writeback report; 1-cycle report->o_pending; held until commit takes it (o_vld&&i_rdy)
// at ROB head. OLDEST_REPORT_KEEPER_STAT_EN adds o_drop_cnt.
module oldest_report_keeper
   import oldest_report_keeper_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic                 i_squash_vld,
   input  rob_idx_t             i_squash_rob_idx,
   input  logic     [WIDTH-1:0] i_vld,
   input  rob_idx_t [WIDTH-1:0] i_rob_idx,
   input  data_t    [WIDTH-1:0] i_datas,
   input  rob_idx_t             i_head_rob_idx,
   output logic                 o_pending,
   output logic                 o_vld,
   input  logic                 i_rdy,
   output rob_idx_t             o_rob_idx,
   output data_t                o_data
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
   ,
   output logic [31:0]          o_drop_cnt
`endif
);

   logic     held_vld_q,  held_vld_d;
   rob_idx_t held_idx_q,  held_idx_d;
   data_t    held_data_q, held_data_d;

   logic     [WIDTH-1:0] masked_vld;
   logic                 cand_vld;
   rob_idx_t             cand_idx;
   data_t                cand_data;
   logic                 held_kill;
   logic                 accept;
   logic                 held_live;
   logic                 load;

   // Reports younger than the squash point never reach selection.
   always_comb begin
      masked_vld = '0;
      for (int i = 0; i < WIDTH; i++) begin
         masked_vld[i] = i_vld[i] &&
                         !(i_squash_vld && older_than(i_squash_rob_idx, i_rob_idx[i]));
      end
   end

   report_tree_min #(.N(WIDTH)) u_tree (
      .i_vld     (masked_vld),
      .i_idx     (i_rob_idx),
      .i_data    (i_datas),
      .o_any_vld (cand_vld),
      .o_idx     (cand_idx),
      .o_data    (cand_data)
   );

   assign o_pending = held_vld_q;
   assign o_vld     = held_vld_q && (held_idx_q == i_head_rob_idx);
   assign o_rob_idx = held_idx_q;
   assign o_data    = held_data_q;

   always_comb begin
      held_kill = i_squash_vld && older_than(i_squash_rob_idx, held_idx_q);
      accept    = o_vld && i_rdy;
      held_live = held_vld_q && !held_kill && !accept;
      load      = !i_flush && cand_vld && (!held_live || older_than(cand_idx, held_idx_q));
   end

   always_comb begin
      held_vld_d  = held_live;
      held_idx_d  = held_idx_q;
      held_data_d = held_data_q;
      if (i_flush) begin
         held_vld_d  = 1'b0;
         held_idx_d  = '0;
         held_data_d = '0;
      end else if (load) begin
         held_vld_d  = 1'b1;
         held_idx_d  = cand_idx;
         held_data_d = cand_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held_vld_q  <= 1'b0;
         held_idx_q  <= '0;
         held_data_q <= '0;
      end else begin
         held_vld_q  <= held_vld_d;
         held_idx_q  <= held_idx_d;
         held_data_q <= held_data_d;
      end
   end

`ifdef OLDEST_REPORT_KEEPER_STAT_EN
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] n_unmasked;
   logic [31:0]      drop_inc;
   logic [31:0]      drop_cnt_q, drop_cnt_d;

   // Every surviving report that is not the one loaded counts as lost; flush discards without counting.
   always_comb begin
      n_unmasked = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n_unmasked = n_unmasked + CNT_W'(masked_vld[i]);
      end
      drop_inc = i_flush ? 32'd0 : 32'(n_unmasked - CNT_W'(load));
      if (drop_cnt_q > (32'hFFFF_FFFF - drop_inc)) drop_cnt_d = 32'hFFFF_FFFF;
      else                                         drop_cnt_d = drop_cnt_q + drop_inc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_cnt_q <= '0;
      else      drop_cnt_q <= drop_cnt_d;
   end

   assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_oldest_report_keeper.sv
// Directed bench for oldest_report_keeper: selection, replacement, wrap, handshake, squash, flush, reset.
module tb_oldest_report_keeper;
   import oldest_report_keeper_pkg::*;

   logic           clk;
   logic           rst;
   logic           i_flush;
   logic           i_squash_vld;
   rob_idx_t       i_squash_rob_idx;
   logic     [3:0] i_vld;
   rob_idx_t [3:0] i_rob_idx;
   data_t    [3:0] i_datas;
   rob_idx_t       i_head_rob_idx;
   logic           o_pending;
   logic           o_vld;
   logic           i_rdy;
   rob_idx_t       o_rob_idx;
   data_t          o_data;
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
   logic [31:0]    o_drop_cnt;
   int unsigned    exp_drop;
`endif

   int total;
   int bad;

   oldest_report_keeper #(.WIDTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_flush          (i_flush),
      .i_squash_vld     (i_squash_vld),
      .i_squash_rob_idx (i_squash_rob_idx),
      .i_vld            (i_vld),
      .i_rob_idx        (i_rob_idx),
      .i_datas          (i_datas),
      .i_head_rob_idx   (i_head_rob_idx),
      .o_pending        (o_pending),
      .o_vld            (o_vld),
      .i_rdy            (i_rdy),
      .o_rob_idx        (o_rob_idx),
      .o_data           (o_data)
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      ,
      .o_drop_cnt       (o_drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic rob_idx_t ri(input logic f, input logic [5:0] i);
      rob_idx_t r;
      r.flipped = f;
      r.idx     = i;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_flush          = 1'b0;
      i_squash_vld     = 1'b0;
      i_squash_rob_idx = '0;
      i_vld            = '0;
      i_rob_idx        = '0;
      i_datas          = '0;
      i_rdy            = 1'b0;
   endtask

   task automatic send1(input logic f, input logic [5:0] idx, input data_t d);
      i_vld        = 4'b0001;
      i_rob_idx[0] = ri(f, idx);
      i_datas[0]   = d;
      step();
      i_vld        = '0;
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      i_head_rob_idx = ri(1'b1, 6'd63);
      #12;
      total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b want=0", o_pending); end
      total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", o_vld); end
      total++; if (o_rob_idx !== 7'h00) begin bad++; $display("FAIL reset_rob_idx got=%0h want=0", o_rob_idx); end
      total++; if (o_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%0h want=0", o_data); end
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      exp_drop = 0;
      total++; if (o_drop_cnt !== 32'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", o_drop_cnt); end
`endif
      rst = 1'b1;
      step();
   endtask

   task automatic test_select();
      i_vld     = 4'b1111;
      i_rob_idx = {ri(1'b0, 6'd3), ri(1'b0, 6'd9), ri(1'b0, 6'd3), ri(1'b0, 6'd5)};
      i_datas   = {4'h4, 4'h3, 4'h2, 4'h1};
      #1;
      total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL sel_latency got=%0b want=0", o_pending); end
      step();
      i_vld = '0;
      total++; if (o_pending !== 1'b1) begin bad++; $display("FAIL sel_pending got=%0b want=1", o_pending); end
      total++; if (o_rob_idx !== ri(1'b0, 6'd3)) begin bad++; $display("FAIL sel_idx got=%0h want=03", o_rob_idx); end
      total++; if (o_data !== 4'h2) begin bad++; $display("FAIL sel_port got=%0h want=2", o_data); end
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      exp_drop += 3;
      total++; if (o_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL sel_drop got=%0d want=%0d", o_drop_cnt, exp_drop); end
`endif
      do_flush();
   endtask

   task automatic test_replace();
      send1(1'b0, 6'd10, 4'h5);
      total++; if (o_rob_idx !== ri(1'b0, 6'd10)) begin bad++; $display("FAIL repl_first got=%0h want=0a", o_rob_idx); end
      send1(1'b0, 6'd4, 4'h6);
      total++; if (o_rob_idx !== ri(1'b0, 6'd4) || o_data !== 4'h6) begin bad++; $display("FAIL repl_older got=%0h/%0h want=04/6", o_rob_idx, o_data); end
      send1(1'b0, 6'd12, 4'h7);
      total++; if (o_rob_idx !== ri(1'b0, 6'd4) || o_data !== 4'h6) begin bad++; $display("FAIL repl_younger got=%0h/%0h want=04/6", o_rob_idx, o_data); end
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      exp_drop += 1;
      total++; if (o_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL repl_drop got=%0d want=%0d", o_drop_cnt, exp_drop); end
`endif
      do_flush();
   endtask

   task automatic test_wrap();
      send1(1'b0, 6'd62, 4'h1);
      send1(1'b1, 6'd1, 4'h2);
      total++; if (o_rob_idx !== ri(1'b0, 6'd62) || o_data !== 4'h1) begin bad++; $display("FAIL wrap_keep got=%0h/%0h want=3e/1", o_rob_idx, o_data); end
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      exp_drop += 1;
`endif
      do_flush();
      send1(1'b1, 6'd1, 4'h2);
      send1(1'b0, 6'd62, 4'h1);
      total++; if (o_rob_idx !== ri(1'b0, 6'd62) || o_data !== 4'h1) begin bad++; $display("FAIL wrap_load got=%0h/%0h want=3e/1", o_rob_idx, o_data); end
      do_flush();
   endtask

   task automatic test_handshake();
      i_head_rob_idx = ri(1'b0, 6'd0);
      send1(1'b0, 6'd7, 4'h9);
      total++; if (o_pending !== 1'b1 || o_vld !== 1'b0) begin bad++; $display("FAIL hs_not_head got=%0b%0b want=10", o_pending, o_vld); end
      i_head_rob_idx = ri(1'b0, 6'd7);
      #1;
      total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL hs_at_head got=%0b want=1", o_vld); end
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (o_vld !== 1'b1 || o_pending !== 1'b1) begin bad++; $display("FAIL hs_stall%0d got=%0b%0b want=11", c, o_pending, o_vld); end
      end
      i_rdy = 1'b1;
      step();
      i_rdy = 1'b0;
      total++; if (o_pending !== 1'b0 || o_vld !== 1'b0) begin bad++; $display("FAIL hs_accept got=%0b%0b want=00", o_pending, o_vld); end
      // Accept and a younger report in the same cycle: the report loads into the freed slot.
      send1(1'b0, 6'd7, 4'h9);
      i_rdy        = 1'b1;
      i_vld        = 4'b0010;
      i_rob_idx[1] = ri(1'b0, 6'd9);
      i_datas[1]   = 4'hA;
      step();
      i_rdy = 1'b0;
      i_vld = '0;
      total++; if (o_pending !== 1'b1 || o_rob_idx !== ri(1'b0, 6'd9) || o_data !== 4'hA) begin bad++; $display("FAIL b2b_reload got=%0b/%0h/%0h want=1/09/a", o_pending, o_rob_idx, o_data); end
      total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL b2b_vld got=%0b want=0", o_vld); end
      i_head_rob_idx = ri(1'b1, 6'd63);
      do_flush();
   endtask

   task automatic test_squash();
      send1(1'b0, 6'd20, 4'h1);
      i_squash_vld     = 1'b1;
      i_squash_rob_idx = ri(1'b0, 6'd15);
      send1(1'b0, 6'd18, 4'h2);
      i_squash_vld     = 1'b0;
      total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL sq_drop got=%0b want=0", o_pending); end
      send1(1'b0, 6'd20, 4'h1);
      i_squash_vld     = 1'b1;
      send1(1'b0, 6'd15, 4'h3);
      i_squash_vld     = 1'b0;
      total++; if (o_pending !== 1'b1 || o_rob_idx !== ri(1'b0, 6'd15) || o_data !== 4'h3) begin bad++; $display("FAIL sq_equal got=%0b/%0h/%0h want=1/0f/3", o_pending, o_rob_idx, o_data); end
      do_flush();
   endtask

   task automatic test_flush_rst();
      send1(1'b0, 6'd7, 4'h5);
      i_flush   = 1'b1;
      i_vld     = 4'b1111;
      i_rob_idx = {ri(1'b0, 6'd1), ri(1'b0, 6'd2), ri(1'b0, 6'd3), ri(1'b0, 6'd4)};
      step();
      i_flush   = 1'b0;
      i_vld     = '0;
      total++; if (o_pending !== 1'b0) begin bad++; $display("FAIL flush_pending got=%0b want=0", o_pending); end
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      total++; if (o_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL flush_drop got=%0d want=%0d", o_drop_cnt, exp_drop); end
`endif
      send1(1'b0, 6'd7, 4'h5);
      total++; if (o_pending !== 1'b1) begin bad++; $display("FAIL rst_preload got=%0b want=1", o_pending); end
      #1 rst = 1'b0;
      #1;
      total++; if (o_pending !== 1'b0 || o_rob_idx !== 7'h00 || o_data !== 4'h0) begin bad++; $display("FAIL async_rst got=%0b/%0h/%0h want=0/0/0", o_pending, o_rob_idx, o_data); end
`ifdef OLDEST_REPORT_KEEPER_STAT_EN
      total++; if (o_drop_cnt !== 32'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", o_drop_cnt); end
`endif
      rst = 1'b1;
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_select();
      test_replace();
      test_wrap();
      test_handshake();
      test_squash();
      test_flush_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
